snoop_coerencia: RTL and testbench

Clocked, parametrised MSI snooping-coherence controller for N_PROC private direct-mapped caches sharing one bus. Holds the per-line state/tag arrays of every cache, arbitrates processor requests round-robin, broadcasts the bus message, applies the requester and snooper state transitions, and sequences owner/victim write-backs and memory reads. Sits between the processor request ports and the memory port, and replaces the per-case combinational transition logic with a full multi-cycle transaction engine.

---
 rtl/snoop_pkg.sv | 32 +++
 rtl/snoop_arbitro_rr.sv | 25 ++
 rtl/snoop_coerencia.sv | 262 ++++++++++++++++++++++++++
 tb/tb_snoop_coerencia.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_pkg.sv
// snoop_pkg: shared encodings for the MSI snooping-coherence controller.
// Line states, bus messages, request opcodes and the transaction FSM states.
package snoop_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10
  } estado_t;

  typedef enum logic [1:0] {
    BUS_NONE   = 2'b00,
    WRITE_MISS = 2'b01,
    INVALIDATE = 2'b10,
    READ_MISS  = 2'b11
  } bus_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    OCIOSO,
    ANALISA,
    BARRAMENTO,
    WRITEBACK,
    MEMORIA,
    CONCLUI
  } fsm_t;

endpackage

// File: rtl/snoop_arbitro_rr.sv
// snoop_arbitro_rr: round-robin request picker. Returns the first set request
// at or after the pointer, wrapping modulo N_PROC.
module snoop_arbitro_rr #(
  parameter  int N_PROC = 3,
  localparam int PW     = $clog2(N_PROC)
) (
  input  logic [N_PROC-1:0] req_valid,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     gnt_idx,
  output logic              gnt_vld
);

  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (req_valid[(int'(ptr) + i) % N_PROC]) begin
        gnt_idx = PW'((int'(ptr) + i) % N_PROC);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_coerencia.sv
// snoop_coerencia: MSI snooping-coherence transaction engine for N_PROC
// direct-mapped caches on one bus. Holds every cache's state/tag array, runs
// one transaction at a time and sequences write-backs and memory reads.
// Optional build macro SNOOP_ESTATISTICA_EN adds saturating 16-bit hit/miss
// counters on ports cont_hit/cont_miss.
module snoop_coerencia
  import snoop_pkg::*;
#(
  parameter  int N_PROC  = 3,
  parameter  int IDX_W   = 2,
  parameter  int TAG_W   = 4,
  parameter  int LAT_MEM = 4,
  localparam int ADDR_W  = TAG_W + IDX_W,
  localparam int PW      = $clog2(N_PROC)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        req_valid,
  input  logic [N_PROC-1:0]        req_op,
  input  logic [N_PROC*ADDR_W-1:0] req_addr,
  output logic [N_PROC-1:0]        req_ack,
  output logic                     resp_hit,
  output logic [1:0]               bus_msg,
  output logic [PW-1:0]            bus_origem,
  output logic                     wb_valid,
  output logic [PW-1:0]            wb_proc,
  output logic                     aborta_acesso_mem,
  output logic                     mem_rd,
  output logic                     ocupado,
  input  logic [PW-1:0]            dbg_proc,
  input  logic [IDX_W-1:0]         dbg_idx,
  output logic [1:0]               dbg_estado
`ifdef SNOOP_ESTATISTICA_EN
  ,
  output logic [15:0]              cont_hit,
  output logic [15:0]              cont_miss
`endif
);

  localparam int LINES = 2 ** IDX_W;
  localparam int CW    = $clog2(LAT_MEM + 1);

  fsm_t             fsm_q;
  estado_t          est_q [N_PROC][LINES];
  logic [TAG_W-1:0] tag_q [N_PROC][LINES];

  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    proc_q;
  op_t              op_q;
  logic [TAG_W-1:0] tag_l_q;
  logic [IDX_W-1:0] idx_l_q;
  logic             hit_q;
  logic             vic_pend_q;
  logic             own_pend_q;
  logic             abort_q;
  logic [PW-1:0]    own_idx_q;
  logic [CW-1:0]    mem_cnt_q;

  logic [PW-1:0]    gnt_idx;
  logic             gnt_vld;

  estado_t          req_est;
  logic [TAG_W-1:0] req_tag;
  logic             a_hit;
  logic             a_vic;
  logic             a_own;
  logic [PW-1:0]    a_own_idx;

  snoop_arbitro_rr #(.N_PROC(N_PROC)) u_arbitro (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  assign ocupado    = (fsm_q != OCIOSO);
  assign dbg_estado = est_q[dbg_proc][dbg_idx];

  // Classify the latched request against the arrays: hit, victim, remote owner
  always_comb begin
    req_est   = est_q[proc_q][idx_l_q];
    req_tag   = tag_q[proc_q][idx_l_q];
    a_hit     = (req_est != INVALID) && (req_tag == tag_l_q);
    a_vic     = !a_hit && (req_est == EXCLUSIVE);
    a_own     = 1'b0;
    a_own_idx = '0;
    for (int p = 0; p < N_PROC; p++) begin
      if ((PW'(p) != proc_q) && (est_q[p][idx_l_q] == EXCLUSIVE) &&
          (tag_q[p][idx_l_q] == tag_l_q)) begin
        a_own     = 1'b1;
        a_own_idx = PW'(p);
      end
    end
  end

  // Transaction FSM with registered outputs and array updates
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q             <= OCIOSO;
      ptr_q             <= '0;
      proc_q            <= '0;
      op_q              <= READ;
      tag_l_q           <= '0;
      idx_l_q           <= '0;
      hit_q             <= 1'b0;
      vic_pend_q        <= 1'b0;
      own_pend_q        <= 1'b0;
      abort_q           <= 1'b0;
      own_idx_q         <= '0;
      mem_cnt_q         <= '0;
      req_ack           <= '0;
      resp_hit          <= 1'b0;
      bus_msg           <= BUS_NONE;
      bus_origem        <= '0;
      wb_valid          <= 1'b0;
      wb_proc           <= '0;
      aborta_acesso_mem <= 1'b0;
      mem_rd            <= 1'b0;
      for (int p = 0; p < N_PROC; p++) begin
        for (int i = 0; i < LINES; i++) begin
          est_q[p][i] <= INVALID;
          tag_q[p][i] <= '0;
        end
      end
    end else begin
      // Pulsed outputs fall back to idle unless a transition drives them
      req_ack           <= '0;
      resp_hit          <= 1'b0;
      bus_msg           <= BUS_NONE;
      bus_origem        <= '0;
      wb_valid          <= 1'b0;
      wb_proc           <= '0;
      aborta_acesso_mem <= 1'b0;
      mem_rd            <= 1'b0;

      case (fsm_q)
        OCIOSO: begin
          if (gnt_vld) begin
            proc_q               <= gnt_idx;
            op_q                 <= op_t'(req_op[gnt_idx]);
            {tag_l_q, idx_l_q}   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            ptr_q                <= (gnt_idx == PW'(N_PROC - 1)) ? '0 : gnt_idx + 1'b1;
            fsm_q                <= ANALISA;
          end
        end

        ANALISA: begin
          hit_q      <= a_hit;
          vic_pend_q <= a_vic;
          own_pend_q <= !a_hit && a_own;
          abort_q    <= !a_hit && a_own;
          own_idx_q  <= a_own_idx;
          if (a_hit && ((op_q == READ) || (req_est == EXCLUSIVE))) begin
            fsm_q    <= CONCLUI;
            req_ack  <= N_PROC'(1) << proc_q;
            resp_hit <= 1'b1;
          end else begin
            fsm_q             <= BARRAMENTO;
            bus_origem        <= proc_q;
            aborta_acesso_mem <= !a_hit && a_own;
            if (a_hit)
              bus_msg <= INVALIDATE;
            else if (op_q == READ)
              bus_msg <= READ_MISS;
            else
              bus_msg <= WRITE_MISS;
          end
        end

        BARRAMENTO: begin
          // Snoopers react to the message broadcast this cycle
          for (int p = 0; p < N_PROC; p++) begin
            if ((PW'(p) != proc_q) && (est_q[p][idx_l_q] != INVALID) &&
                (tag_q[p][idx_l_q] == tag_l_q)) begin
              if (bus_msg == READ_MISS) begin
                if (est_q[p][idx_l_q] == EXCLUSIVE)
                  est_q[p][idx_l_q] <= SHARED;
              end else begin
                est_q[p][idx_l_q] <= INVALID;
              end
            end
          end
          if (hit_q) begin
            fsm_q    <= CONCLUI;
            req_ack  <= N_PROC'(1) << proc_q;
            resp_hit <= 1'b1;
          end else if (vic_pend_q) begin
            fsm_q             <= WRITEBACK;
            vic_pend_q        <= 1'b0;
            wb_valid          <= 1'b1;
            wb_proc           <= proc_q;
            aborta_acesso_mem <= abort_q;
          end else if (own_pend_q) begin
            fsm_q             <= WRITEBACK;
            own_pend_q        <= 1'b0;
            wb_valid          <= 1'b1;
            wb_proc           <= own_idx_q;
            aborta_acesso_mem <= 1'b1;
          end else begin
            fsm_q     <= MEMORIA;
            mem_rd    <= 1'b1;
            mem_cnt_q <= CW'(LAT_MEM - 1);
          end
        end

        WRITEBACK: begin
          // Victim goes first; the owner write-back, if any, follows it
          if (own_pend_q) begin
            own_pend_q        <= 1'b0;
            wb_valid          <= 1'b1;
            wb_proc           <= own_idx_q;
            aborta_acesso_mem <= 1'b1;
          end else if (abort_q) begin
            fsm_q   <= CONCLUI;
            req_ack <= N_PROC'(1) << proc_q;
          end else begin
            fsm_q     <= MEMORIA;
            mem_rd    <= 1'b1;
            mem_cnt_q <= CW'(LAT_MEM - 1);
          end
        end

        MEMORIA: begin
          if (mem_cnt_q == '0) begin
            fsm_q   <= CONCLUI;
            req_ack <= N_PROC'(1) << proc_q;
          end else begin
            mem_cnt_q <= mem_cnt_q - 1'b1;
          end
        end

        CONCLUI: begin
          est_q[proc_q][idx_l_q] <= (op_q == READ) ? SHARED : EXCLUSIVE;
          tag_q[proc_q][idx_l_q] <= tag_l_q;
          fsm_q                  <= OCIOSO;
        end

        default: fsm_q <= OCIOSO;
      endcase
    end
  end

`ifdef SNOOP_ESTATISTICA_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Hit/miss statistics, counted once per completed transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_hit  <= '0;
      cont_miss <= '0;
    end else if (fsm_q == CONCLUI) begin
      if (hit_q)
        cont_hit <= sat_inc(cont_hit);
      else
        cont_miss <= sat_inc(cont_miss);
    end
  end
`endif

endmodule

// File: tb/tb_snoop_coerencia.sv
// tb_snoop_coerencia: directed scenarios plus randomized transactions checked
// against a behavioural MSI model of every cache line.
module tb_snoop_coerencia;

  localparam int N   = 3;
  localparam int LAT = 4;
  localparam int AW  = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_op;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ack;
  logic          resp_hit;
  logic [1:0]    bus_msg;
  logic [1:0]    bus_origem;
  logic          wb_valid;
  logic [1:0]    wb_proc;
  logic          aborta_acesso_mem;
  logic          mem_rd;
  logic          ocupado;
  logic [1:0]    dbg_proc;
  logic [1:0]    dbg_idx;
  logic [1:0]    dbg_estado;
`ifdef SNOOP_ESTATISTICA_EN
  logic [15:0]   cont_hit;
  logic [15:0]   cont_miss;
`endif

  int errors = 0;
  int checks = 0;

  // model: state 0=I 1=S 2=E per [proc][idx], plus tag
  int m_st [N][4];
  int m_tg [N][4];

  int e_ack, e_hit, e_bus, e_memrd, e_wbn, e_abort;
  int e_wb [2];
  int o_ack, o_ackv, o_hit, o_bus, o_bus_cyc, o_busn, o_orig;
  int o_memrd, o_memrdn, o_wbn, o_wb_cyc0, o_abort;
  int o_wb [2];

  snoop_coerencia #(.N_PROC(3), .IDX_W(2), .TAG_W(4), .LAT_MEM(LAT)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_addr          (req_addr),
    .req_ack           (req_ack),
    .resp_hit          (resp_hit),
    .bus_msg           (bus_msg),
    .bus_origem        (bus_origem),
    .wb_valid          (wb_valid),
    .wb_proc           (wb_proc),
    .aborta_acesso_mem (aborta_acesso_mem),
    .mem_rd            (mem_rd),
    .ocupado           (ocupado),
    .dbg_proc          (dbg_proc),
    .dbg_idx           (dbg_idx),
    .dbg_estado        (dbg_estado)
`ifdef SNOOP_ESTATISTICA_EN
    ,
    .cont_hit          (cont_hit),
    .cont_miss         (cont_miss)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 4; i++) begin
        m_st[p][i] = 0;
        m_tg[p][i] = 0;
      end
  endtask

  // Expected outcome of one transaction from the MSI rules; updates the model
  task automatic model_txn(input int p, input int op, input int addr);
    int t, i, own;
    t = addr >> 2;
    i = addr & 3;
    own = -1;
    e_hit = (m_st[p][i] != 0 && m_tg[p][i] == t) ? 1 : 0;
    e_wbn = 0; e_memrd = -1; e_abort = 0; e_bus = 0;
    if (e_hit == 1 && (op == 0 || m_st[p][i] == 2)) begin
      e_ack = 2;
    end else if (e_hit == 1) begin
      e_bus = 2;
      e_ack = 3;
      for (int q = 0; q < N; q++)
        if (q != p && m_st[q][i] != 0 && m_tg[q][i] == t) m_st[q][i] = 0;
    end else begin
      e_bus = (op == 1) ? 1 : 3;
      if (m_st[p][i] == 2) begin
        e_wb[e_wbn] = p;
        e_wbn = e_wbn + 1;
      end
      for (int q = 0; q < N; q++) begin
        if (q != p && m_st[q][i] != 0 && m_tg[q][i] == t) begin
          if (m_st[q][i] == 2) own = q;
          if (op == 1) m_st[q][i] = 0;
          else if (m_st[q][i] == 2) m_st[q][i] = 1;
        end
      end
      if (own >= 0) begin
        e_wb[e_wbn] = own;
        e_wbn = e_wbn + 1;
        e_abort = 1;
        e_ack = 3 + e_wbn;
      end else begin
        e_memrd = 3 + e_wbn;
        e_ack = 3 + e_wbn + LAT;
      end
    end
    m_st[p][i] = (op == 1) ? 2 : 1;
    m_tg[p][i] = t;
  endtask

  // Record DUT activity cycle by cycle until an ack or the cycle budget runs out
  task automatic monitor();
    o_ack = -1; o_ackv = 0; o_hit = -1; o_bus = 0; o_bus_cyc = -1; o_busn = 0;
    o_orig = -1; o_memrd = -1; o_memrdn = 0; o_wbn = 0; o_wb_cyc0 = -1; o_abort = 0;
    o_wb[0] = -1; o_wb[1] = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus_msg != 2'b00) begin
        o_busn++; o_bus = int'(bus_msg); o_bus_cyc = c; o_orig = int'(bus_origem);
      end
      if (mem_rd) begin
        o_memrdn++; o_memrd = c;
      end
      if (wb_valid) begin
        if (o_wbn == 0) o_wb_cyc0 = c;
        if (o_wbn < 2) o_wb[o_wbn] = int'(wb_proc);
        o_wbn++;
        if (aborta_acesso_mem) o_abort = 1;
      end
      if (req_ack != '0) begin
        o_ack = c; o_ackv = int'(req_ack); o_hit = int'(resp_hit);
        break;
      end
    end
  endtask

  task automatic run_txn(input int p, input int op, input int addr);
    @(negedge clock);
    model_txn(p, op, addr);
    req_op[p] = op[0];
    req_addr[p*AW +: AW] = AW'(addr);
    req_valid[p] = 1'b1;
    monitor();
    req_valid[p] = 1'b0;
  endtask

  task automatic read_dbg(input int p, input int i, output int s);
    dbg_proc = 2'(p);
    dbg_idx = 2'(i);
    #1;
    s = int'(dbg_estado);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int s;
    reset = 1'b1;
    #12;
    checks++; if (req_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", req_ack); end
    checks++; if (resp_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", resp_hit); end
    checks++; if (bus_msg !== 2'b00) begin errors++; $display("FAIL reset_bus: got %b want 00", bus_msg); end
    checks++; if (wb_valid !== 1'b0 || aborta_acesso_mem !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got wb=%b ab=%b mr=%b want 0", wb_valid, aborta_acesso_mem, mem_rd);
    end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 4; i++) begin
        read_dbg(p, i, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL reset_line p%0d i%0d: got %0d want 0", p, i, s); end
      end
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_plan();
    int s;
    run_txn(0, 0, 'h15);
    checks++; if (o_bus !== 3 || o_bus_cyc !== 2) begin errors++; $display("FAIL p1_bus: got %0d@%0d want 3@2", o_bus, o_bus_cyc); end
    checks++; if (o_memrd !== 3) begin errors++; $display("FAIL p1_memrd: got %0d want 3", o_memrd); end
    checks++; if (o_ack !== 7 || o_ackv !== 1 || o_hit !== 0) begin
      errors++; $display("FAIL p1_ack: got cyc%0d v%0d hit%0d want cyc7 v1 hit0", o_ack, o_ackv, o_hit);
    end
    @(posedge clock); #1;
    read_dbg(0, 1, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL p1_state: got %0d want 1", s); end

    run_txn(0, 0, 'h15);
    checks++; if (o_ack !== 2 || o_hit !== 1 || o_busn !== 0) begin
      errors++; $display("FAIL p2_hit: got cyc%0d hit%0d bus%0d want cyc2 hit1 bus0", o_ack, o_hit, o_busn);
    end

    run_txn(1, 0, 'h15);
    run_txn(1, 1, 'h15);
    checks++; if (o_bus !== 2 || o_bus_cyc !== 2 || o_ack !== 3 || o_hit !== 1) begin
      errors++; $display("FAIL p3_inv: got bus%0d@%0d ack%0d hit%0d want bus2@2 ack3 hit1", o_bus, o_bus_cyc, o_ack, o_hit);
    end
    @(posedge clock); #1;
    read_dbg(1, 1, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL p3_p1_state: got %0d want 2", s); end
    read_dbg(0, 1, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL p3_p0_state: got %0d want 0", s); end

    run_txn(2, 0, 'h15);
    checks++; if (o_bus !== 3 || o_wbn !== 1 || o_wb[0] !== 1 || o_abort !== 1) begin
      errors++; $display("FAIL p4_owner: got bus%0d wbn%0d wb%0d ab%0d want bus3 wbn1 wb1 ab1", o_bus, o_wbn, o_wb[0], o_abort);
    end
    checks++; if (o_memrdn !== 0 || o_ack !== 4) begin
      errors++; $display("FAIL p4_nomem: got memrd%0d ack%0d want memrd0 ack4", o_memrdn, o_ack);
    end
    @(posedge clock); #1;
    read_dbg(1, 1, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL p4_p1_state: got %0d want 1", s); end
    read_dbg(2, 1, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL p4_p2_state: got %0d want 1", s); end

    run_txn(1, 1, 'h15);
    run_txn(1, 1, 'h25);
    checks++; if (o_wb_cyc0 !== 3 || o_wb[0] !== 1 || o_memrd !== 4 || o_ack !== 8) begin
      errors++; $display("FAIL p5_victim: got wb%0d@%0d memrd%0d ack%0d want wb1@3 memrd4 ack8", o_wb[0], o_wb_cyc0, o_memrd, o_ack);
    end
    @(posedge clock); #1;
    read_dbg(1, 1, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL p5_state: got %0d want 2", s); end
  endtask

  task automatic test_back_to_back();
    int ops [3];
    do_reset();
    ops[0] = 0; ops[1] = 1; ops[2] = 0;
    @(negedge clock);
    for (int p = 0; p < N; p++) begin
      req_op[p] = ops[p][0];
      req_addr[p*AW +: AW] = 6'h15;
    end
    req_valid = 3'b111;
    for (int k = 0; k < N; k++) begin
      model_txn(k, ops[k], 'h15);
      monitor();
      checks++; if (o_ackv !== (1 << k)) begin errors++; $display("FAIL rr_order%0d: got ack %0d want %0d", k, o_ackv, 1 << k); end
      checks++; if (o_ack !== e_ack + ((k > 0) ? 1 : 0)) begin
        errors++; $display("FAIL rr_cycle%0d: got %0d want %0d", k, o_ack, e_ack + ((k > 0) ? 1 : 0));
      end
      if (o_ackv > 0 && o_ackv < 8) req_valid = req_valid & ~3'(o_ackv);
      else req_valid = '0;
    end
  endtask

  task automatic test_reset_mid();
    int s, seen, ack_seen;
    do_reset();
    @(negedge clock);
    req_op[2] = 1'b0;
    req_addr[2*AW +: AW] = 6'h3A;
    req_valid[2] = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_rd) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_mid_memrd: got %0d want 1", seen); end
    reset = 1'b1;
    #1;
    checks++; if (ocupado !== 1'b0 || mem_rd !== 1'b0 || bus_msg !== 2'b00) begin
      errors++; $display("FAIL rst_mid_outputs: got ocup%b memrd%b bus%b want 0", ocupado, mem_rd, bus_msg);
    end
    ack_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (req_ack != '0) ack_seen = 1;
    end
    checks++; if (ack_seen !== 0) begin errors++; $display("FAIL rst_mid_noack: got %0d want 0", ack_seen); end
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 4; i++) begin
        read_dbg(p, i, s);
        checks++; if (s !== 0) begin errors++; $display("FAIL rst_mid_line p%0d i%0d: got %0d want 0", p, i, s); end
      end
    @(negedge clock);
    model_clear();
    reset = 1'b0;
    model_txn(2, 0, 'h3A);
    monitor();
    req_valid[2] = 1'b0;
    checks++; if (o_ack !== e_ack || o_ackv !== 4) begin
      errors++; $display("FAIL rst_mid_rearb: got cyc%0d v%0d want cyc%0d v4", o_ack, o_ackv, e_ack);
    end
  endtask

  task automatic test_random(input int n);
    int p, op, addr, s;
    for (int k = 0; k < n; k++) begin
      p = int'($urandom_range(0, 2));
      op = int'($urandom_range(0, 1));
      addr = (int'($urandom_range(0, 2)) << 2) | int'($urandom_range(0, 3));
      run_txn(p, op, addr);
      checks++; if (o_ack !== e_ack || o_ackv !== (1 << p)) begin
        errors++; $display("FAIL rnd%0d ack: got cyc%0d v%0d want cyc%0d v%0d", k, o_ack, o_ackv, e_ack, 1 << p);
      end
      checks++; if (o_hit !== e_hit) begin errors++; $display("FAIL rnd%0d hit: got %0d want %0d", k, o_hit, e_hit); end
      checks++; if (o_busn !== ((e_bus != 0) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d bus_cycles: got %0d want %0d", k, o_busn, (e_bus != 0) ? 1 : 0);
      end
      if (e_bus != 0) begin
        checks++; if (o_bus !== e_bus || o_bus_cyc !== 2 || o_orig !== p) begin
          errors++; $display("FAIL rnd%0d bus: got %0d@%0d from%0d want %0d@2 from%0d", k, o_bus, o_bus_cyc, o_orig, e_bus, p);
        end
      end
      checks++; if (o_memrd !== e_memrd || o_memrdn !== ((e_memrd >= 0) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d memrd: got %0d x%0d want %0d", k, o_memrd, o_memrdn, e_memrd);
      end
      checks++; if (o_wbn !== e_wbn || o_abort !== e_abort) begin
        errors++; $display("FAIL rnd%0d wb: got n%0d ab%0d want n%0d ab%0d", k, o_wbn, o_abort, e_wbn, e_abort);
      end
      for (int w = 0; w < 2; w++) begin
        if (w < e_wbn) begin
          checks++; if (o_wb[w] !== e_wb[w]) begin
            errors++; $display("FAIL rnd%0d wb_proc%0d: got %0d want %0d", k, w, o_wb[w], e_wb[w]);
          end
        end
      end
      @(posedge clock); #1;
      for (int q = 0; q < N; q++)
        for (int i = 0; i < 4; i++) begin
          read_dbg(q, i, s);
          checks++; if (s !== m_st[q][i]) begin
            errors++; $display("FAIL rnd%0d line p%0d i%0d: got %0d want %0d", k, q, i, s, m_st[q][i]);
          end
        end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_addr = '0;
    dbg_proc = '0;
    dbg_idx = '0;
    model_clear();
    test_reset();
    test_plan();
    test_back_to_back();
    test_reset_mid();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
